// File: rtl/rom_port_unit.sv
// -----------------------------------------------------------------------------
// rom_port_unit
//
// Program-ROM and I/O-port companion for the 4-bit CPU. It follows the CPU's
// 8-phase instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3), captures the 12-bit
// fetch address from the shared nibble bus and returns the 8-bit opcode as two
// nibbles in M1/M2. It also owns a 256x8 program store (host-writable) and one
// 4-bit I/O port, reached through SRC (chip select), WRR (write) and RDR (read).
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-low
//   halt       freezes phase and all state (program-store writes still land)
//   sync       CPU sync, high during X3; the following cycle is A1
//   rom_cmd    CPU ROM command strobe
//   bus_i      nibble from CPU data_o, qualified by bus_i_en
//   bus_i_en   CPU data_en
//   bus_o      nibble to CPU data_i, 0 when not driving
//   bus_en     unit is driving the bus (M1, M2 or X2 only)
//   prog_we    host program-store write strobe
//   prog_addr  host write address
//   prog_data  host write byte
//   io_in      input port, passed through during an RDR X2
//   io_out     registered output port, written by WRR
// -----------------------------------------------------------------------------
module rom_port_unit #(
  parameter logic [3:0] CHIP_ID = 4'h0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       halt,
  input  logic       sync,
  input  logic       rom_cmd,
  input  logic [3:0] bus_i,
  input  logic       bus_i_en,
  output logic [3:0] bus_o,
  output logic       bus_en,
  input  logic       prog_we,
  input  logic [7:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic [3:0] io_in,
  output logic [3:0] io_out
);

  localparam logic [3:0] OP_IO  = 4'hE;
  localparam logic [3:0] OP_WRR = 4'h2;
  localparam logic [3:0] OP_RDR = 4'hA;

  typedef enum logic [3:0] {
    PH_A1   = 4'd0,
    PH_A2   = 4'd1,
    PH_A3   = 4'd2,
    PH_M1   = 4'd3,
    PH_M2   = 4'd4,
    PH_X1   = 4'd5,
    PH_X2   = 4'd6,
    PH_X3   = 4'd7,
    PH_IDLE = 4'd8
  } phase_e;

  phase_e      phase_q, phase_d;
  logic [11:0] addr_q, addr_d;
  logic        sel_q, sel_d;
  logic [7:0]  fetch_q, fetch_d;
  logic [3:0]  op_hi_q, op_hi_d;
  logic [3:0]  op_lo_q, op_lo_d;
  logic        io_pending_q, io_pending_d;
  logic        io_sel_q, io_sel_d;
  logic [3:0]  io_out_q, io_out_d;

  logic [7:0]  prog_mem [256];

  // NOTE: the program store has no reset: clearing 256 bytes on reset would
  // turn it into a large reset tree for contents the host always loads anyway.
  always_ff @(posedge clock) begin
    if (prog_we) begin
      prog_mem[prog_addr] <= prog_data;
    end
  end

  // Phase sequencing. sync wins from any phase (including an in-flight
  // instruction, which it aborts); without sync X3 falls back to IDLE.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned and a latch is never inferred.
    phase_d = phase_q;
    if (!halt) begin
      if (sync) begin
        phase_d = PH_A1;
      end else begin
        unique case (phase_q)
          PH_A1:   phase_d = PH_A2;
          PH_A2:   phase_d = PH_A3;
          PH_A3:   phase_d = PH_M1;
          PH_M1:   phase_d = PH_M2;
          PH_M2:   phase_d = PH_X1;
          PH_X1:   phase_d = PH_X2;
          PH_X2:   phase_d = PH_X3;
          default: phase_d = PH_IDLE;  // X3 and IDLE
        endcase
      end
    end
  end

  // Datapath next-state: address latches, fetch, opcode tracking, I/O port.
  always_comb begin
    addr_d       = addr_q;
    sel_d        = sel_q;
    fetch_d      = fetch_q;
    op_hi_d      = op_hi_q;
    op_lo_d      = op_lo_q;
    io_pending_d = io_pending_q;
    io_sel_d     = io_sel_q;
    io_out_d     = io_out_q;

    if (!halt) begin
      unique case (phase_q)
        PH_A1: if (bus_i_en) addr_d[3:0] = bus_i;
        PH_A2: if (bus_i_en) addr_d[7:4] = bus_i;
        PH_A3: begin
          if (bus_i_en) addr_d[11:8] = bus_i;
          // Chip select uses the A3 nibble as it is being latched.
          sel_d   = (addr_d[11:8] == CHIP_ID);
          // Registered read: a host write on this same edge is not visible,
          // so a same-address collision returns the old byte.
          fetch_d = prog_mem[addr_q[7:0]];
        end
        PH_M1: if (sel_q) op_hi_d = fetch_q[7:4];
        PH_M2: begin
          if (sel_q) begin
            op_lo_d = fetch_q[3:0];
            // The CM-ROM strobe in M2 of an I/O opcode arms the X2 action.
            if (op_hi_q == OP_IO && rom_cmd) io_pending_d = 1'b1;
          end
        end
        PH_X2: begin
          if (rom_cmd && bus_i_en) io_sel_d = (bus_i == CHIP_ID);
          // WRR acts on the chip selected by an earlier SRC, not this X2's.
          if (io_pending_q && io_sel_q && bus_i_en && op_lo_q == OP_WRR) begin
            io_out_d = bus_i;
          end
        end
        default: ;
      endcase

      // Leaving the instruction (normally or by a resync abort) drops any
      // armed I/O action.
      if (phase_d == PH_A1 || phase_d == PH_IDLE) io_pending_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q      <= PH_IDLE;
      addr_q       <= '0;
      sel_q        <= 1'b0;
      fetch_q      <= '0;
      op_hi_q      <= '0;
      op_lo_q      <= '0;
      io_pending_q <= 1'b0;
      io_sel_q     <= 1'b0;
      io_out_q     <= '0;
    end else begin
      phase_q      <= phase_d;
      addr_q       <= addr_d;
      sel_q        <= sel_d;
      fetch_q      <= fetch_d;
      op_hi_q      <= op_hi_d;
      op_lo_q      <= op_lo_d;
      io_pending_q <= io_pending_d;
      io_sel_q     <= io_sel_d;
      io_out_q     <= io_out_d;
    end
  end

  // Bus drive is decoded straight from registered state, so an asynchronous
  // reset (phase -> IDLE) releases the bus immediately.
  always_comb begin
    bus_o  = 4'h0;
    bus_en = 1'b0;
    unique case (phase_q)
      PH_M1: if (sel_q) begin
        bus_en = 1'b1;
        bus_o  = fetch_q[7:4];
      end
      PH_M2: if (sel_q) begin
        bus_en = 1'b1;
        bus_o  = fetch_q[3:0];
      end
      PH_X2: if (io_pending_q && io_sel_q && op_lo_q == OP_RDR) begin
        bus_en = 1'b1;
        bus_o  = io_in;
      end
      default: ;
    endcase
  end

  assign io_out = io_out_q;

endmodule

// File: tb/tb_rom_port_unit.sv
// -----------------------------------------------------------------------------
// tb_rom_port_unit
//
// Drives whole instruction cycles into rom_port_unit. For each driven cycle an
// instruction-level reference model pushes the expected bus_en / bus_o /
// io_out into a queue; a monitor on the falling edge pops and compares.
// Directed instructions cover fetch, deselect, SRC/WRR/RDR, resync abort,
// halt, same-address write collision and mid-cycle reset, followed by a
// randomized instruction stream.
// -----------------------------------------------------------------------------
module tb_rom_port_unit;

  localparam logic [3:0] CHIP = 4'h0;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       halt = 1'b0;
  logic       sync = 1'b0;
  logic       rom_cmd = 1'b0;
  logic [3:0] bus_i = 4'h0;
  logic       bus_i_en = 1'b0;
  logic [3:0] bus_o;
  logic       bus_en;
  logic       prog_we = 1'b0;
  logic [7:0] prog_addr = 8'h00;
  logic [7:0] prog_data = 8'h00;
  logic [3:0] io_in = 4'h0;
  logic [3:0] io_out;

  rom_port_unit #(.CHIP_ID(CHIP)) dut (
    .clock    (clock),
    .reset    (reset),
    .halt     (halt),
    .sync     (sync),
    .rom_cmd  (rom_cmd),
    .bus_i    (bus_i),
    .bus_i_en (bus_i_en),
    .bus_o    (bus_o),
    .bus_en   (bus_en),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .io_in    (io_in),
    .io_out   (io_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       en;
    logic [3:0] data;
    logic [3:0] io;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc_id = 0;

  // Reference model state, at instruction level.
  logic [7:0] m_mem [256];
  logic [3:0] m_io_out = 4'h0;
  logic       m_io_sel = 1'b0;
  logic [3:0] m_lat [3];

  task automatic check(input string name, input int id, input logic [7:0] act,
                       input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, id, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("bus_en", e.id, {7'd0, bus_en}, {7'd0, e.en});
      check("bus_o",  e.id, {4'd0, bus_o},  {4'd0, e.data});
      check("io_out", e.id, {4'd0, io_out}, {4'd0, e.io});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [3:0] rnd4();
    return 4'($urandom);
  endfunction

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 3))
      0:       return 8'hE2;
      1:       return 8'hEA;
      2:       return 8'hE5;
      default: return 8'($urandom);
    endcase
  endfunction

  // Apply one cycle's inputs and record what the DUT must show this cycle.
  task automatic put(input logic s, input logic en, input logic [3:0] b,
                     input logic cmd, input logic h, input logic we,
                     input logic [7:0] wa, input logic [7:0] wd,
                     input logic [3:0] io, input logic xen,
                     input logic [3:0] xd);
    exp_t e;
    sync = s; bus_i_en = en; bus_i = b; rom_cmd = cmd; halt = h;
    prog_we = we; prog_addr = wa; prog_data = wd; io_in = io;
    e.en = xen; e.data = xd; e.io = m_io_out; e.id = cyc_id;
    exp_q.push_back(e);
    cyc_id++;
  endtask

  task automatic cyc(input logic s, input logic en, input logic [3:0] b,
                     input logic cmd, input logic h, input logic we,
                     input logic [7:0] wa, input logic [7:0] wd,
                     input logic [3:0] io, input logic xen,
                     input logic [3:0] xd);
    put(s, en, b, cmd, h, we, wa, wd, io, xen, xd);
    @(posedge clock);
    #1;
  endtask

  // Non-instruction cycles (X3 or IDLE): bus noise must never be driven back.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1, rnd4(), 1'($urandom), 1'b0, 1'b0, 8'h00, 8'h00,
          rnd4(), 1'b0, 4'h0);
    end
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, a, d, rnd4(), 1'b0, 4'h0);
    m_mem[a] = d;
  endtask

  // One instruction: a sync cycle, then A1..X2. The DUT is left in X3 (or in
  // A1 when aborted by sync during X1).
  task automatic run_instr(input logic [11:0] a, input logic [2:0] a_en,
                           input logic m2_cmd, input logic x2_cmd,
                           input logic [3:0] x2_bus, input logic x2_en,
                           input logic [3:0] io_val, input logic wr,
                           input logic [7:0] wd, input int halt_n,
                           input logic abort_x1);
    logic [7:0] fa;
    logic [7:0] b;
    logic       sel;
    logic       pend;
    logic       rdr;
    cyc(1'b1, 1'b0, rnd4(), 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, rnd4(), 1'b0, 4'h0);
    if (a_en[0]) m_lat[0] = a[3:0];
    cyc(1'b0, a_en[0], a[3:0], 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, rnd4(), 1'b0, 4'h0);
    if (a_en[1]) m_lat[1] = a[7:4];
    cyc(1'b0, a_en[1], a[7:4], 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, rnd4(), 1'b0, 4'h0);
    if (a_en[2]) m_lat[2] = a[11:8];
    fa  = {m_lat[1], m_lat[0]};
    sel = (m_lat[2] == CHIP);
    b   = m_mem[fa];
    cyc(1'b0, a_en[2], a[11:8], 1'b0, 1'b0, wr, fa, wd, rnd4(), 1'b0, 4'h0);
    if (wr) m_mem[fa] = wd;
    for (int k = 0; k < halt_n; k++) begin
      cyc(1'b1, 1'b1, rnd4(), 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, rnd4(),
          sel, sel ? b[7:4] : 4'h0);
    end
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, rnd4(),
        sel, sel ? b[7:4] : 4'h0);
    cyc(1'b0, 1'b0, 4'h0, m2_cmd, 1'b0, 1'b0, 8'h00, 8'h00, rnd4(),
        sel, sel ? b[3:0] : 4'h0);
    pend = sel && (b[7:4] == 4'hE) && m2_cmd;
    cyc(abort_x1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, rnd4(), 1'b0, 4'h0);
    if (!abort_x1) begin
      rdr = pend && m_io_sel && (b[3:0] == 4'hA);
      cyc(1'b0, x2_en, x2_bus, x2_cmd, 1'b0, 1'b0, 8'h00, 8'h00, io_val,
          rdr, rdr ? io_val : 4'h0);
      if (pend && m_io_sel && x2_en && b[3:0] == 4'h2) m_io_out = x2_bus;
      if (x2_cmd && x2_en) m_io_sel = (x2_bus == CHIP);
    end
  endtask

  initial begin
    logic [7:0] b;
    for (int i = 0; i < 3; i++) m_lat[i] = 4'h0;

    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    // Reset state, plus program-store load while the unit waits in IDLE.
    idle(2);
    for (int i = 0; i < 16; i++) host_write(8'(i), pick_byte());
    host_write(8'h00, 8'h00);
    host_write(8'h35, 8'hA7);
    host_write(8'h40, 8'hEA);
    host_write(8'h41, 8'h0A);
    host_write(8'h50, 8'hE2);
    host_write(8'h51, 8'hEA);
    host_write(8'h52, 8'hE5);

    // Fetch, then deselect.
    run_instr(12'h035, 3'b111, 1'b0, 1'b0, 4'h0, 1'b0, rnd4(), 1'b0, 8'h00, 0, 1'b0);
    idle(2);
    run_instr(12'h135, 3'b111, 1'b0, 1'b0, 4'h0, 1'b0, rnd4(), 1'b0, 8'h00, 0, 1'b0);

    // SRC chip 0, WRR, RDR, no-op I/O code.
    run_instr(12'h000, 3'b111, 1'b0, 1'b1, CHIP, 1'b1, rnd4(), 1'b0, 8'h00, 0, 1'b0);
    run_instr(12'h050, 3'b111, 1'b1, 1'b0, 4'h9, 1'b1, rnd4(), 1'b0, 8'h00, 0, 1'b0);
    run_instr(12'h051, 3'b111, 1'b1, 1'b0, rnd4(), 1'b1, 4'h6, 1'b0, 8'h00, 0, 1'b0);
    run_instr(12'h052, 3'b111, 1'b1, 1'b0, 4'h3, 1'b1, 4'h6, 1'b0, 8'h00, 0, 1'b0);

    // Deselect the port via SRC chip 5: WRR and RDR must do nothing.
    run_instr(12'h000, 3'b111, 1'b0, 1'b1, 4'h5, 1'b1, rnd4(), 1'b0, 8'h00, 0, 1'b0);
    run_instr(12'h050, 3'b111, 1'b1, 1'b0, 4'h3, 1'b1, rnd4(), 1'b0, 8'h00, 0, 1'b0);
    run_instr(12'h051, 3'b111, 1'b1, 1'b0, 4'h0, 1'b0, 4'h6, 1'b0, 8'h00, 0, 1'b0);

    // Reselect, then abort an armed RDR by sync in X1; the next instruction
    // (opcode 0A, not I/O) must not read the port.
    run_instr(12'h000, 3'b111, 1'b0, 1'b1, CHIP, 1'b1, rnd4(), 1'b0, 8'h00, 0, 1'b0);
    run_instr(12'h040, 3'b111, 1'b1, 1'b0, 4'h0, 1'b0, 4'h6, 1'b0, 8'h00, 0, 1'b1);
    run_instr(12'h041, 3'b111, 1'b1, 1'b0, 4'h0, 1'b0, 4'h6, 1'b0, 8'h00, 0, 1'b0);

    // Halt for three cycles in M1.
    run_instr(12'h035, 3'b111, 1'b0, 1'b0, 4'h0, 1'b0, rnd4(), 1'b0, 8'h00, 3, 1'b0);

    // Host write to the fetch address on the A3 edge: old byte, then new.
    run_instr(12'h035, 3'b111, 1'b0, 1'b0, 4'h0, 1'b0, rnd4(), 1'b1, 8'h3C, 0, 1'b0);
    run_instr(12'h035, 3'b111, 1'b0, 1'b0, 4'h0, 1'b0, rnd4(), 1'b0, 8'h00, 0, 1'b0);

    // Reset asserted mid-M1 while the unit drives the bus.
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, rnd4(), 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, rnd4(), 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, rnd4(), 1'b0, 4'h0);
    cyc(1'b0, 1'b1, CHIP, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, rnd4(), 1'b0, 4'h0);
    m_lat[0] = 4'h5; m_lat[1] = 4'h3; m_lat[2] = CHIP;
    b = m_mem[8'h35];
    put(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, rnd4(), 1'b1, b[7:4]);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("rst_bus_en", -1, {7'd0, bus_en}, 8'h00);
    check("rst_bus_o",  -1, {4'd0, bus_o},  8'h00);
    check("rst_io_out", -1, {4'd0, io_out}, 8'h00);
    m_io_out = 4'h0;
    m_io_sel = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    idle(4);
    run_instr(12'h035, 3'b111, 1'b0, 1'b0, 4'h0, 1'b0, rnd4(), 1'b0, 8'h00, 0, 1'b0);

    // Randomized instruction stream.
    for (int i = 0; i < 80; i++) begin
      logic [11:0] a;
      logic [2:0]  a_en;
      if ($urandom_range(0, 3) == 0) host_write(8'($urandom_range(0, 15)), pick_byte());
      a = {($urandom_range(0, 3) == 0) ? 4'h1 : CHIP, 4'h0, 4'($urandom_range(0, 15))};
      a_en = ($urandom_range(0, 9) == 0) ? (3'b111 & ~(3'b001 << $urandom_range(0, 2)))
                                         : 3'b111;
      run_instr(a, a_en, 1'($urandom), $urandom_range(0, 3) == 0,
                ($urandom_range(0, 1) == 1) ? CHIP : rnd4(),
                $urandom_range(0, 4) != 0, rnd4(),
                $urandom_range(0, 7) == 0, pick_byte(),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0,
                $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end

    idle(2);
    @(negedge clock);
    #1;
    check("queue_drained", -1, 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rom_port_unit.md
# rom_port_unit

Program-ROM and I/O-port companion for the 4-bit CPU. It sits on the CPU's shared nibble bus, downstream of the CPU's `sync`, `data_o`/`data_en` and `rom_cmd` outputs, and upstream of its `data_i`. The unit decodes the 8-phase instruction cycle, captures the 12-bit fetch address and returns the 8-bit opcode in two nibbles. It also provides a 256-byte program store with a host write port and one 4-bit I/O port, handled through SRC/WRR/RDR.

## Interface
- `CHIP_ID`, default 4'h0: value of address bits [11:8] that selects this unit; also the SRC chip number for the I/O port.
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low.
- `halt`  in  1: when high, freezes phase and all state; outputs hold.
- `sync`  in  1: CPU sync; high during X3, so the next cycle is A1.
- `rom_cmd`  in  1: CPU ROM command strobe.
- `bus_i`  in  4: CPU data_o.
- `bus_i_en`  in  1: CPU data_en; bus_i is ignored when low.
- `bus_o`  out  4: nibble to CPU data_i; 0 when not driving.
- `bus_en`  out  1: unit is driving the bus.
- `prog_we`  in  1: host program-store write.
- `prog_addr`  in  8: host write address.
- `prog_data`  in  8: host write byte.
- `io_in`  in  4: input port, sampled for RDR.
- `io_out`  out  4: registered output port, written by WRR.

## Operation
- Phase counter states: IDLE, A1, A2, A3, M1, M2, X1, X2, X3 (encode 0–7 plus IDLE).
  - Reset state is IDLE.
  - From IDLE or any phase, `sync`=1 forces the next phase to A1. This is the resync rule.
  - Otherwise phases advance A1→…→X3.
  - At X3 with `sync`=0, the next phase is IDLE.
- Address capture (bus_i_en=1 required):
  - A1 latches addr[3:0]; A2 latches addr[7:4]; A3 latches addr[11:8].
  - `sel` = (addr[11:8]==CHIP_ID), registered at the end of A3.
  - If bus_i_en=0 in A1–A3, the address nibble holds its old value.
- Fetch: at the end of A3, `fetch` ← mem[addr[7:0]]. The address is taken from the A1/A2 latches plus the A3 bus value.
  - M1: if sel, bus_o=fetch[7:4], bus_en=1.
  - M2: if sel, bus_o=fetch[3:0], bus_en=1.
  - When sel=0, bus_en=0 and bus_o=0.
- Opcode tracking: `op_hi`/`op_lo` capture the fetched nibbles in M1/M2 whenever sel=1.
  - `io_pending` is set at the end of M2 when sel=1, op_hi=4'hE and rom_cmd=1.
  - This is the I/O-instruction M2 CM-ROM strobe.
- SRC: in X2 with rom_cmd=1 and bus_i_en=1, `io_sel` ← (bus_i==CHIP_ID). `io_sel` persists until the next SRC or reset.
- WRR (op_lo=4'h2): in X2 of the same instruction, if io_pending and io_sel and bus_i_en, then io_out ← bus_i at the end of X2.
- RDR (op_lo=4'hA): in X2, if io_pending and io_sel, then bus_o=io_in and bus_en=1. io_in is passed combinationally during X2.
- Other I/O codes (op_hi=E, op_lo≠2,A) have no effect.
- io_pending clears at the end of X3 or on entry to IDLE.
- Program store: 256×8.
  - prog_we writes at a clock edge.
  - When a write and a fetch hit the same address in the same A3 edge, the fetch returns the old byte.
  - The program store is not cleared by reset; its contents are undefined until written.
- `halt`=1 blocks all state updates (phase, latches, fetch, io_out) except `prog_we` writes. Combinational bus_o/bus_en continue from the frozen state.

## Timing
- Reset values:
  - phase=IDLE, sel=0, io_sel=0, io_pending=0, io_out=0, fetch=0.
  - bus_en=0, bus_o=0.
- bus_en/bus_o are decoded from the registered phase and flags, with no extra register stage. Read latency is address at A3 to data in M1, i.e. one cycle.
- bus_en is never high outside M1, M2 and X2.
- Reset asserted mid-cycle: outputs go to their reset values immediately, and the unit waits in IDLE for sync.
- A sync arriving mid-cycle (e.g. in M1) aborts the current instruction. io_pending is cleared and the next phase is A1.

## Test plan
- **Reset:** assert reset mid-M1 with bus_en=1 → bus_en=0, io_out=0 within the same cycle; after release, phase stays IDLE until sync.
- **Fetch:** write mem[0x35]=0xA7, CHIP_ID=0, drive address 0x035 over A1..A3 → bus_o=A in M1 and 7 in M2, bus_en=1 in both phases only.
- **Deselect:** address 0x135 with CHIP_ID=0 → bus_en=0 for the whole cycle.
- **WRR:** SRC with chip 0 (X2, rom_cmd=1, bus_i=0), then fetch of 0xE2 with rom_cmd=1 in M2 and bus_i=0x9 in X2 → io_out=9 after X2; with io_sel=0, io_out is unchanged.
- **RDR:** io_sel=1, fetch 0xEA, io_in=0x6 → bus_o=6, bus_en=1 in X2 only.
- **Halt and same-address collision:**
  - halt for 3 cycles during M1 → bus_o is held at the same nibble and the phase resumes correctly.
  - prog_we to the fetch address on the A3 edge → the old byte is returned, and the new byte is returned on the next fetch.
